interface_serial_medida: RTL and testbench
==========================================

# interface_serial_medida

Parametrised successor to the fixed DHT11 measurement interface. On a `medir` request it raises a trigger line to the external sensor front-end, then receives one UART-style frame carrying the measurement: start bit, `DATA_BITS` data bits LSB first, parity bit, stop bit. It checks parity and framing, retries on error or timeout, and latches the validated payload. Its outputs split the payload into two half-width fields (humidity and temperature) for the display and transmission blocks.

## Interface

- `CLKS_PER_BIT`, 5208: clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 4.
- `DATA_BITS`, 32: payload width; must be even and ≥ 2.
- `PARITY_ODD`, 1: 1 means odd parity over data+parity; 0 means even.
- `MEDIR_CYCLES`, 1000: duration of the `medir_out` trigger pulse.
- `TIMEOUT_CYCLES`, 5_000_000: maximum wait from the trigger falling to the start-bit edge.
- `MAX_RETRIES`, 2: extra attempts after the first failure.

Ports:

- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `medir`  in  1  measurement request; level is sampled in `INICIAL`
- `rx_serial`  in  1  serial line, idle high, asynchronous to `clock`
- `medir_out`  out  1  trigger to the sensor front-end
- `pronto_medida`  out  1  one-cycle pulse when a valid frame has been latched
- `erro`  out  1  one-cycle pulse when all attempts have failed
- `umidade_out`  out  DATA_BITS/2  upper half of the last valid payload
- `temperatura_out`  out  DATA_BITS/2  lower half of the last valid payload
- `ocupado`  out  1  high in every state except `INICIAL`
- `db_estado`  out  4  current state code, for debug

## Operation

- `rx_serial` passes through a 2-flop synchroniser before any use. Only the synchronised value is sampled.
- States and codes:
  - `INICIAL` (0): idle. `medir`=1 loads the retry counter with `MAX_RETRIES` and moves to `PULSO`.
  - `PULSO` (1): `medir_out`=1 for exactly `MEDIR_CYCLES` cycles, then moves to `ESPERA_START`.
  - `ESPERA_START` (2): timeout counter runs.
    - Synchronised rx = 0 moves to `START`.
    - Counter reaching `TIMEOUT_CYCLES` moves to `FALHA`.
  - `START` (3): waits `CLKS_PER_BIT/2` cycles, then samples rx.
    - Sample 0 moves to `DADOS`.
    - Sample 1 is a glitch: return to `ESPERA_START`. The timeout counter is not reset.
  - `DADOS` (4): samples one bit every `CLKS_PER_BIT` cycles, shifting in LSB first, `DATA_BITS` times. Then moves to `PARIDADE`.
  - `PARIDADE` (5): samples one bit after `CLKS_PER_BIT` cycles, then moves to `STOP`.
  - `STOP` (6): samples one bit after `CLKS_PER_BIT` cycles, then moves to `VERIFICA`.
  - `VERIFICA` (7): one cycle.
    - Frame is OK when the stop bit = 1 and XOR(data, parity) = `PARITY_ODD`. OK moves to `ARMAZENA`.
    - Otherwise moves to `FALHA`.
  - `ARMAZENA` (8): latches `umidade_out`=shift[DATA_BITS-1:DATA_BITS/2] and `temperatura_out`=shift[DATA_BITS/2-1:0]. Pulses `pronto_medida`, then moves to `INICIAL`.
  - `FALHA` (9):
    - Retry counter > 0: decrement it and move to `PULSO`.
    - Retry counter = 0: pulse `erro` and move to `INICIAL`.
- Output holding: `umidade_out` and `temperatura_out` change only in `ARMAZENA`. A failed frame never alters them.
- `medir` is ignored while `ocupado`=1. A request is never queued.
- Unused state codes go to `INICIAL` on the next clock.

## Timing

- Reset values, taking effect on the next edge while `reset`=1:
  - state `INICIAL`
  - `medir_out`=0, `pronto_medida`=0, `erro`=0, `ocupado`=0
  - both data outputs 0
  - all counters 0
- Reset takes priority over every event, including mid-frame.
- Sampling points, with t0 the cycle the synchronised falling edge is seen:
  - start bit sampled at t0+CLKS_PER_BIT/2
  - data bit k sampled at t0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT
  - parity bit k=DATA_BITS, stop bit k=DATA_BITS+1
- Latency from the stop-bit sample to `pronto_medida`=1 is 2 cycles (`VERIFICA`, then `ARMAZENA`). The new data is visible in the same cycle as the pulse.
- `medir_out` rises the cycle after `medir` is accepted and stays high exactly `MEDIR_CYCLES` cycles.
- `pronto_medida` and `erro` are never both high, and each lasts exactly 1 cycle.
- Rx activity outside `ESPERA_START`…`STOP` is ignored.

## Test plan

All scenarios use `CLKS_PER_BIT`=16, `MEDIR_CYCLES`=8, `TIMEOUT_CYCLES`=2000 and `MAX_RETRIES`=2, with other parameters at default.

- Good frame: 1-cycle `medir`, wait for `medir_out` to fall, send 32'hAAAABBBB with correct odd parity. Expect `pronto_medida` 1 cycle, `umidade_out`=16'hAAAA, `temperatura_out`=16'hBBBB, `medir_out` high exactly 8 cycles.
- Parity error, then recovery:
  - Send 32'h12345678 with wrong parity. Expect a second `medir_out` pulse and no `pronto_medida`.
  - Respond with a good 32'h0F0F00F0. Expect `umidade_out`=16'h0F0F, `temperatura_out`=16'h00F0.
- Silent line: never drive rx low. Expect 3 `medir_out` pulses, then `erro` 1 cycle and a return to `INICIAL`. Outputs keep their prior values.
- Framing and glitch:
  - A 4-cycle low glitch causes no reception.
  - A frame with stop bit = 0 triggers a retry.
  - `medir` pulsed during reception is ignored: exactly one `pronto_medida` results.
- Reset mid-frame: assert `reset` during bit 10 of a frame. Expect all outputs 0 next cycle and `db_estado`=0. A subsequent good frame is received correctly.
- Even-parity build (`PARITY_ODD`=0, `DATA_BITS`=16): send 16'hA5C3 with even parity. Expect `umidade_out`=8'hA5, `temperatura_out`=8'hC3.

Source files
------------

// File: rtl/interface_serial_medida.sv
// rtl/interface_serial_medida.sv - triggered serial measurement receiver with parity/framing check and retries
module interface_serial_medida #(
    parameter int unsigned CLKS_PER_BIT   = 5208,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned PARITY_ODD     = 1,
    parameter int unsigned MEDIR_CYCLES   = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     medir,
    input  logic                     rx_serial,
    output logic                     medir_out,
    output logic                     pronto_medida,
    output logic                     erro,
    output logic [DATA_BITS/2-1:0]   umidade_out,
    output logic [DATA_BITS/2-1:0]   temperatura_out,
    output logic                     ocupado,
    output logic [3:0]               db_estado
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic        PAR_EXP  = (PARITY_ODD != 0);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        PULSO        = 4'd1,
        ESPERA_START = 4'd2,
        START        = 4'd3,
        DADOS        = 4'd4,
        PARIDADE     = 4'd5,
        STOP         = 4'd6,
        VERIFICA     = 4'd7,
        ARMAZENA     = 4'd8,
        FALHA        = 4'd9
    } estado_t;

    estado_t                estado;
    logic                   rx_meta;
    logic                   rx_sync;
    logic [31:0]            cnt;
    logic [31:0]            tmo;
    logic [31:0]            bit_idx;
    logic [31:0]            retry;
    logic [DATA_BITS-1:0]   shift;
    logic                   parity_bit;
    logic                   stop_bit;

    assign db_estado = estado;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= INICIAL;
            rx_meta         <= 1'b1;
            rx_sync         <= 1'b1;
            cnt             <= '0;
            tmo             <= '0;
            bit_idx         <= '0;
            retry           <= '0;
            shift           <= '0;
            parity_bit      <= 1'b0;
            stop_bit        <= 1'b0;
            medir_out       <= 1'b0;
            pronto_medida   <= 1'b0;
            erro            <= 1'b0;
            ocupado         <= 1'b0;
            umidade_out     <= '0;
            temperatura_out <= '0;
        end else begin
            rx_meta       <= rx_serial;
            rx_sync       <= rx_meta;
            pronto_medida <= 1'b0;
            erro          <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (medir) begin
                        retry     <= MAX_RETRIES;
                        cnt       <= 32'd1;
                        medir_out <= 1'b1;
                        ocupado   <= 1'b1;
                        estado    <= PULSO;
                    end
                end
                PULSO: begin
                    if (cnt >= MEDIR_CYCLES) begin
                        medir_out <= 1'b0;
                        tmo       <= '0;
                        estado    <= ESPERA_START;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ESPERA_START: begin
                    if (!rx_sync) begin
                        cnt    <= 32'd1;
                        estado <= START;
                    end else if (tmo >= TIMEOUT_CYCLES - 1) begin
                        estado <= FALHA;
                    end else begin
                        tmo <= tmo + 32'd1;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was a glitch; tmo keeps running.
                    if (cnt >= HALF_BIT) begin
                        cnt     <= 32'd1;
                        bit_idx <= '0;
                        estado  <= rx_sync ? ESPERA_START : DADOS;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                DADOS: begin
                    if (cnt >= CLKS_PER_BIT) begin
                        cnt   <= 32'd1;
                        shift <= {rx_sync, shift[DATA_BITS-1:1]};
                        if (bit_idx >= DATA_BITS - 1) begin
                            estado <= PARIDADE;
                        end else begin
                            bit_idx <= bit_idx + 32'd1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                PARIDADE: begin
                    if (cnt >= CLKS_PER_BIT) begin
                        cnt        <= 32'd1;
                        parity_bit <= rx_sync;
                        estado     <= STOP;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                STOP: begin
                    if (cnt >= CLKS_PER_BIT) begin
                        stop_bit <= rx_sync;
                        estado   <= VERIFICA;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                VERIFICA: begin
                    // Outputs load on the edge into ARMAZENA so data and pulse appear together.
                    if (stop_bit && ((^shift ^ parity_bit) == PAR_EXP)) begin
                        umidade_out     <= shift[DATA_BITS-1:DATA_BITS/2];
                        temperatura_out <= shift[DATA_BITS/2-1:0];
                        pronto_medida   <= 1'b1;
                        estado          <= ARMAZENA;
                    end else begin
                        estado <= FALHA;
                    end
                end
                ARMAZENA: begin
                    ocupado <= 1'b0;
                    estado  <= INICIAL;
                end
                FALHA: begin
                    if (retry != 0) begin
                        retry     <= retry - 32'd1;
                        cnt       <= 32'd1;
                        medir_out <= 1'b1;
                        estado    <= PULSO;
                    end else begin
                        erro    <= 1'b1;
                        ocupado <= 1'b0;
                        estado  <= INICIAL;
                    end
                end
                default: begin
                    medir_out <= 1'b0;
                    ocupado   <= 1'b0;
                    estado    <= INICIAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interface_serial_medida.sv
// tb/tb_interface_serial_medida.sv - directed self-checking bench for interface_serial_medida
module tb_interface_serial_medida;

    logic        clock = 1'b0;
    logic        reset;
    logic        medir, rx, medir2, rx2;
    logic        medir_out, pronto_medida, erro, ocupado;
    logic [15:0] umidade_out, temperatura_out;
    logic [3:0]  db_estado;
    logic        medir_out2, pronto2, erro2, ocupado2;
    logic [7:0]  umidade2, temperatura2;
    logic [3:0]  db_estado2;

    int total = 0;
    int bad   = 0;

    int mo_run = 0, mo_pulses = 0, mo_last = 0;
    int mo2_run = 0, mo2_pulses = 0;
    int pronto_cnt = 0, erro_cnt = 0, pronto2_cnt = 0;
    logic [15:0] cap_um = '0, cap_te = '0;
    logic [7:0]  cap2_um = '0, cap2_te = '0;
    logic prev_pronto = 0, prev_erro = 0, long_pulse = 0, both_high = 0;

    interface_serial_medida #(
        .CLKS_PER_BIT(16), .MEDIR_CYCLES(8), .TIMEOUT_CYCLES(2000), .MAX_RETRIES(2)
    ) dut (
        .clock(clock), .reset(reset), .medir(medir), .rx_serial(rx),
        .medir_out(medir_out), .pronto_medida(pronto_medida), .erro(erro),
        .umidade_out(umidade_out), .temperatura_out(temperatura_out),
        .ocupado(ocupado), .db_estado(db_estado)
    );

    interface_serial_medida #(
        .CLKS_PER_BIT(16), .DATA_BITS(16), .PARITY_ODD(0), .MEDIR_CYCLES(8),
        .TIMEOUT_CYCLES(2000), .MAX_RETRIES(2)
    ) dut_even (
        .clock(clock), .reset(reset), .medir(medir2), .rx_serial(rx2),
        .medir_out(medir_out2), .pronto_medida(pronto2), .erro(erro2),
        .umidade_out(umidade2), .temperatura_out(temperatura2),
        .ocupado(ocupado2), .db_estado(db_estado2)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (medir_out) mo_run++;
        else begin
            if (mo_run != 0) begin mo_pulses++; mo_last = mo_run; end
            mo_run = 0;
        end
        if (medir_out2) mo2_run++;
        else begin
            if (mo2_run != 0) mo2_pulses++;
            mo2_run = 0;
        end
        if (pronto_medida) begin pronto_cnt++; cap_um = umidade_out; cap_te = temperatura_out; end
        if (erro) erro_cnt++;
        if (pronto2) begin pronto2_cnt++; cap2_um = umidade2; cap2_te = temperatura2; end
        if ((pronto_medida && prev_pronto) || (erro && prev_erro)) long_pulse = 1;
        if (pronto_medida && erro) both_high = 1;
        prev_pronto = pronto_medida;
        prev_erro   = erro;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic [31:0] d, input int n, input logic par, input logic stp);
        logic [35:0] f = '1;
        f[0] = 1'b0;
        for (int k = 0; k < n; k++) f[k+1] = d[k];
        f[n+1] = par;
        f[n+2] = stp;
        return f;
    endfunction

    task automatic send(input logic [35:0] f, input int len, input bit sel, input int medir_bit);
        for (int i = 0; i < len; i++) begin
            for (int c = 0; c < 16; c++) begin
                @(negedge clock);
                if (sel) rx2 = f[i];
                else rx = f[i];
                if (medir_bit >= 0) medir = (i == medir_bit && c == 0);
            end
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int n = 0;
        while (mo_pulses < target && n < budget) begin @(negedge clock); n++; end
        check(tag, 64'(mo_pulses >= target), 64'd1);
    endtask

    task automatic pulse_medir();
        @(negedge clock); medir = 1'b1;
        @(negedge clock); medir = 1'b0;
    endtask

    initial begin
        int pb, cb, eb, n;
        logic [35:0] f;
        rx = 1'b1; rx2 = 1'b1; medir = 1'b0; medir2 = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_state", db_estado, 4'd0);
        check("rst_medir_out", medir_out, 1'b0);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_pronto_erro", {pronto_medida, erro}, 2'b00);
        check("rst_data", {umidade_out, temperatura_out}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // good frame
        pb = mo_pulses; cb = pronto_cnt;
        pulse_medir();
        check("t1_medir_out_rise", medir_out, 1'b1);
        check("t1_state_pulso", db_estado, 4'd1);
        check("t1_ocupado", ocupado, 1'b1);
        wait_pulses(pb + 1, 100, "t1_trigger_timeout");
        check("t1_pulse_len", mo_last, 8);
        send(mk(32'hAAAABBBB, 32, 1'b1, 1'b1), 35, 0, -1); rx = 1'b1;
        repeat (5) @(negedge clock);
        check("t1_pronto_count", pronto_cnt, cb + 1);
        check("t1_umidade_at_pulse", cap_um, 16'hAAAA);
        check("t1_temperatura_at_pulse", cap_te, 16'hBBBB);
        check("t1_state_idle", db_estado, 4'd0);
        check("t1_ocupado_idle", ocupado, 1'b0);

        // parity error then recovery
        pb = mo_pulses; cb = pronto_cnt;
        pulse_medir();
        wait_pulses(pb + 1, 100, "t2_trigger_timeout");
        send(mk(32'h12345678, 32, 1'b1, 1'b1), 35, 0, -1); rx = 1'b1;
        wait_pulses(pb + 2, 100, "t2_retry_timeout");
        check("t2_no_pronto", pronto_cnt, cb);
        check("t2_data_held", umidade_out, 16'hAAAA);
        send(mk(32'h0F0F00F0, 32, 1'b1, 1'b1), 35, 0, -1); rx = 1'b1;
        repeat (5) @(negedge clock);
        check("t2_pronto_count", pronto_cnt, cb + 1);
        check("t2_umidade", cap_um, 16'h0F0F);
        check("t2_temperatura", cap_te, 16'h00F0);
        check("t2_pulses", mo_pulses, pb + 2);

        // silent line
        pb = mo_pulses; cb = pronto_cnt; eb = erro_cnt;
        pulse_medir();
        n = 0;
        while (erro_cnt == eb && n < 8000) begin @(negedge clock); n++; end
        check("t3_erro_seen", 64'(erro_cnt == eb + 1), 64'd1);
        repeat (3) @(negedge clock);
        check("t3_pulses", mo_pulses, pb + 3);
        check("t3_no_pronto", pronto_cnt, cb);
        check("t3_data_held", {umidade_out, temperatura_out}, 32'h0F0F00F0);
        check("t3_state_idle", db_estado, 4'd0);
        check("t3_ocupado", ocupado, 1'b0);

        // glitch, stop-bit error, medir ignored while busy
        pb = mo_pulses; cb = pronto_cnt;
        pulse_medir();
        wait_pulses(pb + 1, 100, "t4_trigger_timeout");
        repeat (2) @(negedge clock);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        check("t4_glitch_state", db_estado, 4'd2);
        send(mk(32'h11111111, 32, 1'b1, 1'b0), 35, 0, -1); rx = 1'b1;
        wait_pulses(pb + 2, 100, "t4_stop_retry_timeout");
        check("t4_stop_no_pronto", pronto_cnt, cb);
        send(mk(32'hDEADBEEF, 32, 1'b1, 1'b1), 35, 0, 5); rx = 1'b1; medir = 1'b0;
        repeat (40) @(negedge clock);
        check("t4_single_pronto", pronto_cnt, cb + 1);
        check("t4_umidade", cap_um, 16'hDEAD);
        check("t4_temperatura", cap_te, 16'hBEEF);
        check("t4_no_extra_trigger", mo_pulses, pb + 2);
        check("t4_state_idle", db_estado, 4'd0);

        // reset mid-frame during data bit 10
        pb = mo_pulses;
        pulse_medir();
        wait_pulses(pb + 1, 100, "t5_trigger_timeout");
        f = mk(32'h5A5A5A5A, 32, 1'b1, 1'b1);
        send(f, 11, 0, -1);
        rx = f[11];
        repeat (8) @(negedge clock);
        check("t5_state_dados", db_estado, 4'd4);
        reset = 1'b1;
        @(negedge clock);
        check("t5_rst_state", db_estado, 4'd0);
        check("t5_rst_data", {umidade_out, temperatura_out}, 32'h0);
        check("t5_rst_flags", {medir_out, pronto_medida, erro, ocupado}, 4'b0000);
        reset = 1'b0; rx = 1'b1;
        @(negedge clock);
        pb = mo_pulses; cb = pronto_cnt;
        pulse_medir();
        wait_pulses(pb + 1, 100, "t5_trigger_timeout2");
        send(mk(32'hCAFE1234, 32, 1'b1, 1'b1), 35, 0, -1); rx = 1'b1;
        repeat (5) @(negedge clock);
        check("t5_pronto_count", pronto_cnt, cb + 1);
        check("t5_data", {cap_um, cap_te}, 32'hCAFE1234);

        // even parity, 16-bit build
        pb = mo2_pulses;
        @(negedge clock); medir2 = 1'b1;
        @(negedge clock); medir2 = 1'b0;
        n = 0;
        while (mo2_pulses == pb && n < 100) begin @(negedge clock); n++; end
        check("t6_trigger_seen", 64'(mo2_pulses == pb + 1), 64'd1);
        send(mk(32'h0000A5C3, 16, 1'b0, 1'b1), 19, 1, -1); rx2 = 1'b1;
        repeat (5) @(negedge clock);
        check("t6_pronto_count", pronto2_cnt, 1);
        check("t6_umidade", cap2_um, 8'hA5);
        check("t6_temperatura", cap2_te, 8'hC3);

        check("pulse_width_one", long_pulse, 1'b0);
        check("pronto_erro_exclusive", both_high, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
